// File: rtl/regfile_rr_writer_if.sv
// Handshake and dump bundle for regfile_rr_writer.
// master: requesters and dump consumer. slave: the register file wrapper.
// Write side:
//   req_valid, req_addr and req_data come from the requesters.
//   req_ready and grant_id come from the wrapper.
// Dump side:
//   dump_start comes from the consumer.
//   dump_busy, dump_valid, dump_addr and dump_data come from the wrapper.
interface regfile_rr_writer_if #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [2:0]         grant_id;
    logic               dump_start;
    logic               dump_busy;
    logic               dump_valid;
    logic [AW-1:0]      dump_addr;
    logic [DW-1:0]      dump_data;

    modport master (
        output req_valid, req_addr, req_data, dump_start,
        input  req_ready, grant_id,
        input  dump_busy, dump_valid, dump_addr, dump_data
    );

    modport slave (
        input  req_valid, req_addr, req_data, dump_start,
        output req_ready, grant_id,
        output dump_busy, dump_valid, dump_addr, dump_data
    );
endinterface

// File: rtl/regfile_rr_writer.sv
// DEPTH x DW register array with one write port shared round-robin by NREQ
// requesters, plus a dump sequencer that streams a snapshot in address order.
// Ports:
//   clk   - clock.
//   reset - synchronous, active-high reset.
//   bus   - slave side of regfile_rr_writer_if, carrying the write requests,
//           the one-hot grant and the dump stream.
module regfile_rr_writer #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input logic               clk,
    input logic               reset,
    regfile_rr_writer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        DUMP
    } state_t;

    state_t          state;
    logic [AW-1:0]   idx;
    logic [2:0]      ptr;
    logic [DW-1:0]   mem [DEPTH];

    logic [NREQ-1:0] gnt;
    logic [2:0]      gid;
    logic            any;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;

    // Cyclic search from ptr. The first pass covers ptr..NREQ-1 and the
    // second covers 0..ptr-1, so the loop indices stay constant.
    always_comb begin
        gnt   = '0;
        gid   = '0;
        any   = 1'b0;
        waddr = '0;
        wdata = '0;
        if (state == IDLE && !bus.dump_start) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!any && bus.req_valid[i] && i >= int'(ptr)) begin
                    any   = 1'b1;
                    gnt[i] = 1'b1;
                    gid   = 3'(i);
                    waddr = bus.req_addr[i*AW +: AW];
                    wdata = bus.req_data[i*DW +: DW];
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!any && bus.req_valid[i] && i < int'(ptr)) begin
                    any   = 1'b1;
                    gnt[i] = 1'b1;
                    gid   = 3'(i);
                    waddr = bus.req_addr[i*AW +: AW];
                    wdata = bus.req_data[i*DW +: DW];
                end
            end
        end
    end

    assign bus.req_ready  = gnt;
    assign bus.grant_id   = gid;
    assign bus.dump_busy  = (state == DUMP);
    assign bus.dump_valid = (state == DUMP);
    assign bus.dump_addr  = idx;
    assign bus.dump_data  = (state == DUMP) ? mem[idx] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.dump_start) begin
                        state <= DUMP;
                        idx   <= '0;
                    end else if (any) begin
                        mem[waddr] <= wdata;
                        ptr <= (gid == 3'(NREQ-1)) ? 3'd0 : gid + 3'd1;
                    end
                end
                DUMP: begin
                    if (idx == AW'(DEPTH-1)) begin
                        state <= IDLE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end
endmodule
